// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between the i-fetch and load/store requesters.
// Tie-break: round-robin when MEM_ARB_ROUND_ROBIN_EN is defined, fixed d-priority otherwise.
`ifndef LEN_MEM_ADDR
`define LEN_MEM_ADDR 32
`endif
`ifndef LEN_WORD
`define LEN_WORD 32
`endif

module mem_arbiter #(
    parameter int unsigned ADDR_W = `LEN_MEM_ADDR,
    parameter int unsigned WORD_W = `LEN_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_order,
    input  logic              i_io,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [WORD_W-1:0] i_wdata,
    output logic              i_accepted,
    output logic              i_accessed,
    output logic [WORD_W-1:0] i_rdata,
    input  logic              d_order,
    input  logic              d_io,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_accepted,
    output logic              d_accessed,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_order,
    output logic              mem_io,
    output logic [ADDR_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_accepted,
    input  logic              mem_accessed,
    input  logic [WORD_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state;
    state_t              state_nx;
    logic                owner;          // 0 = i, 1 = d
    logic                io_q;
    logic [ADDR_W-1:0]   address_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                last_grant;
    logic                any_order;
    logic                grant_d;
    logic                capture;

    always_comb begin
        any_order = i_order | d_order;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_d = (i_order & d_order) ? ~last_grant : d_order;
`else
        // last_grant is tracked but cannot change the fixed-priority outcome
        grant_d = d_order | (i_order & d_order & last_grant);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        i_accepted = 1'b0;
        d_accepted = 1'b0;
        i_accessed = 1'b0;
        d_accessed = 1'b0;
        mem_order  = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_order && !rst) begin
                    i_accepted = ~grant_d;
                    d_accepted = grant_d;
                    state_nx   = ISSUE;
                end
            end
            ISSUE: begin
                mem_order = 1'b1;
                if (mem_accepted) begin
                    if (mem_accessed) begin
                        capture  = 1'b1;
                        state_nx = RESP;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_accessed) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                i_accessed = ~owner;
                d_accessed = owner;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= 1'b0;
            io_q       <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
            last_grant <= 1'b1;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            if (state == IDLE && any_order) begin
                owner      <= grant_d;
                last_grant <= grant_d;
                io_q       <= grant_d ? d_io      : i_io;
                address_q  <= grant_d ? d_address : i_address;
                wdata_q    <= grant_d ? d_wdata   : i_wdata;
            end
            if (capture && !io_q) begin
                if (owner) begin
                    d_rdata <= mem_rdata;
                end else begin
                    i_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_io      = io_q;
    assign mem_address = address_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps

module tb_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned WW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_order = 1'b0, d_order = 1'b0, i_io = 1'b0, d_io = 1'b0;
    logic [AW-1:0] i_address = '0, d_address = '0;
    logic [WW-1:0] i_wdata = '0, d_wdata = '0;
    logic          i_accepted, d_accepted, i_accessed, d_accessed;
    logic [WW-1:0] i_rdata, d_rdata;
    logic          mem_order, mem_io;
    logic [AW-1:0] mem_address;
    logic [WW-1:0] mem_wdata;
    logic          mem_accepted = 1'b0, mem_accessed = 1'b0;
    logic [WW-1:0] mem_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: one transaction record plus memory-progress flags.
    bit            m_busy, m_taken, m_done, m_own, m_io, m_lg;
    logic [AW-1:0] m_addr;
    logic [WW-1:0] m_wdata, m_ir, m_dr;
    bit            i_took, d_took;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .WORD_W(WW)) dut (
        .clk(clk), .rst(rst),
        .i_order(i_order), .i_io(i_io), .i_address(i_address), .i_wdata(i_wdata),
        .i_accepted(i_accepted), .i_accessed(i_accessed), .i_rdata(i_rdata),
        .d_order(d_order), .d_io(d_io), .d_address(d_address), .d_wdata(d_wdata),
        .d_accepted(d_accepted), .d_accessed(d_accessed), .d_rdata(d_rdata),
        .mem_order(mem_order), .mem_io(mem_io), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_accepted(mem_accepted),
        .mem_accessed(mem_accessed), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit any, win_d, e_iacc, e_dacc, e_mo, e_iax, e_dax;
        if (rst) begin
            chk("rst_ctl", 64'({i_accepted, d_accepted, i_accessed, d_accessed, mem_order, mem_io}), 64'd0);
            chk("rst_mem_address", 64'(mem_address), 64'd0);
            chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
            chk("rst_i_rdata", 64'(i_rdata), 64'd0);
            chk("rst_d_rdata", 64'(d_rdata), 64'd0);
            m_busy = 0; m_taken = 0; m_done = 0; m_own = 0; m_io = 0; m_lg = 1;
            m_addr = '0; m_wdata = '0; m_ir = '0; m_dr = '0;
            i_took = 0; d_took = 0;
        end else begin
            any = i_order | d_order;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_d = (i_order && d_order) ? !m_lg : d_order;
`else
            win_d = d_order;
`endif
            e_iacc = !m_busy && any && !win_d;
            e_dacc = !m_busy && any && win_d;
            e_mo   = m_busy && !m_taken && !m_done;
            e_iax  = m_done && !m_own;
            e_dax  = m_done && m_own;
            chk("i_accepted", 64'(i_accepted), 64'(e_iacc));
            chk("d_accepted", 64'(d_accepted), 64'(e_dacc));
            chk("mem_order", 64'(mem_order), 64'(e_mo));
            chk("i_accessed", 64'(i_accessed), 64'(e_iax));
            chk("d_accessed", 64'(d_accessed), 64'(e_dax));
            chk("i_rdata", 64'(i_rdata), 64'(m_ir));
            chk("d_rdata", 64'(d_rdata), 64'(m_dr));
            if (e_mo) begin
                chk("mem_io", 64'(mem_io), 64'(m_io));
                chk("mem_address", 64'(mem_address), 64'(m_addr));
                chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            end
            i_took = e_iacc;
            d_took = e_dacc;
            if (m_done) begin
                m_busy = 0;
                m_done = 0;
            end else if (!m_busy) begin
                if (any) begin
                    m_busy  = 1;
                    m_taken = 0;
                    m_own   = win_d;
                    m_lg    = win_d;
                    m_io    = win_d ? d_io : i_io;
                    m_addr  = win_d ? d_address : i_address;
                    m_wdata = win_d ? d_wdata : i_wdata;
                end
            end else begin
                if (!m_taken) begin
                    if (mem_accepted) begin
                        m_taken = 1;
                        if (mem_accessed) m_done = 1;
                    end
                end else if (mem_accessed) begin
                    m_done = 1;
                end
                if (m_done && !m_io) begin
                    if (m_own) m_dr = mem_rdata;
                    else       m_ir = mem_rdata;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g[$];
        int exp_g[4];
        int mo_cnt, ax_cnt, ax_cyc, sp_ax;

        tick(); adv();
        tick(); adv();
        rst = 1'b0;

        // Continuous tie with ideal memory
        mem_accepted = 1; mem_accessed = 1; mem_rdata = 32'h0000_1111;
        i_io = 0; d_io = 0; i_address = 16'h0100; d_address = 16'h0200;
        i_order = 1; d_order = 1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (i_accepted) g.push_back(0);
            if (d_accepted) g.push_back(1);
            adv();
        end
        i_order = 0; d_order = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{1, 1, 1, 1};
`endif
        chk("tie_grant_count", 64'(g.size()), 64'd4);
        for (int k = 0; k < 4; k++)
            chk("tie_grant_seq", 64'((k < g.size()) ? g[k] : 2), 64'(exp_g[k]));

        // Single read, ideal memory
        d_io = 0; d_address = 16'h0010; mem_rdata = 32'hDEADBEEF; d_order = 1;
        tick(); chk("rd_d_accepted_c0", 64'(d_accepted), 64'd1); adv();
        d_order = 0;
        tick();
        chk("rd_mem_order_c1", 64'(mem_order), 64'd1);
        chk("rd_mem_address_c1", 64'(mem_address), 64'h10);
        adv();
        tick();
        chk("rd_d_accessed_c2", 64'(d_accessed), 64'd1);
        chk("rd_d_rdata_c2", 64'(d_rdata), 64'hDEADBEEF);
        adv();

        // Slow memory: accept after 3 held cycles, complete 4 cycles after acceptance
        d_address = 16'h0020;
        mo_cnt = 0; ax_cnt = 0; ax_cyc = -1;
        for (int c = 0; c < 14; c++) begin
            d_order      = (c == 0);
            mem_accepted = (c == 4);
            mem_accessed = (c == 8);
            mem_rdata    = (c == 8) ? 32'hCAFEF00D : $urandom;
            tick();
            if (mem_order) mo_cnt++;
            if (d_accessed) begin ax_cnt++; ax_cyc = c; end
            adv();
        end
        chk("slow_mem_order_cycles", 64'(mo_cnt), 64'd4);
        chk("slow_d_accessed_count", 64'(ax_cnt), 64'd1);
        chk("slow_d_accessed_cycle", 64'(ax_cyc), 64'd9);
        chk("slow_d_rdata", 64'(d_rdata), 64'hCAFEF00D);

        // i read to seed i_rdata, then an i write that must not disturb it
        mem_accepted = 1; mem_accessed = 1; mem_rdata = 32'h5555AAAA;
        i_io = 0; i_address = 16'h0030; i_order = 1;
        tick(); chk("wr_seed_i_accepted", 64'(i_accepted), 64'd1); adv();
        i_order = 0;
        tick(); adv();
        tick(); chk("wr_seed_i_rdata", 64'(i_rdata), 64'h5555AAAA); adv();
        i_io = 1; i_wdata = 32'h12345678; i_address = 16'h0040; mem_rdata = 32'h0BADF00D; i_order = 1;
        tick(); chk("wr_i_accepted", 64'(i_accepted), 64'd1); adv();
        i_order = 0;
        tick();
        chk("wr_mem_io", 64'(mem_io), 64'd1);
        chk("wr_mem_wdata", 64'(mem_wdata), 64'h12345678);
        adv();
        tick();
        chk("wr_i_accessed", 64'(i_accessed), 64'd1);
        chk("wr_i_rdata_kept", 64'(i_rdata), 64'h5555AAAA);
        adv();
        tick(); chk("wr_i_rdata_after", 64'(i_rdata), 64'h5555AAAA); adv();
        i_io = 0;

        // Spurious memory handshakes
        sp_ax = 0;
        d_io = 0; d_address = 16'h0050;
        for (int c = 0; c < 8; c++) begin
            d_order      = (c == 1);
            mem_accepted = (c >= 2 && c <= 4);
            mem_accessed = (c == 0 || c == 5);
            mem_rdata    = (c == 5) ? 32'h600DCAFE : 32'hFFFF0000;
            tick();
            if (c <= 5 && (i_accessed || d_accessed)) sp_ax++;
            if (c == 5) chk("spur_d_rdata_held", 64'(d_rdata), 64'hCAFEF00D);
            if (c == 6) begin
                chk("spur_d_accessed", 64'(d_accessed), 64'd1);
                chk("spur_d_rdata_new", 64'(d_rdata), 64'h600DCAFE);
            end
            adv();
        end
        chk("spur_no_early_accessed", 64'(sp_ax), 64'd0);
        chk("spur_i_rdata_held", 64'(i_rdata), 64'h5555AAAA);

        // Asynchronous reset while waiting on memory
        mem_accepted = 1; mem_accessed = 0; d_address = 16'h0060; d_order = 1;
        tick(); chk("arst_d_accepted", 64'(d_accepted), 64'd1); adv();
        d_order = 0;
        tick(); chk("arst_issue", 64'(mem_order), 64'd1); adv();
        mem_accepted = 0;
        #1;
        i_order = 1; i_io = 0; i_address = 16'h0070;
        rst = 1;
        #1;
        chk("arst_ctl_now", 64'({i_accepted, d_accepted, i_accessed, d_accessed, mem_order, mem_io}), 64'd0);
        chk("arst_mem_address_now", 64'(mem_address), 64'd0);
        chk("arst_rdata_now", 64'({i_rdata, d_rdata}), 64'd0);
        tick(); adv();
        rst = 0; mem_accepted = 1; mem_accessed = 1;
        tick(); chk("arst_post_i_accepted", 64'(i_accepted), 64'd1); adv();
        i_order = 0;
        tick(); adv();
        tick(); adv();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (!i_order || i_took) begin
                i_order   = ($urandom_range(0, 2) != 0);
                i_io      = 1'($urandom_range(0, 1));
                i_address = AW'($urandom);
                i_wdata   = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                i_order = 0;
            end
            if (!d_order || d_took) begin
                d_order   = ($urandom_range(0, 2) != 0);
                d_io      = 1'($urandom_range(0, 1));
                d_address = AW'($urandom);
                d_wdata   = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                d_order = 0;
            end
            mem_accepted = 1'($urandom_range(0, 1));
            mem_accessed = ($urandom_range(0, 2) == 0);
            mem_rdata    = $urandom;
            tick();
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
